shift_sequencer: RTL

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_seq_pkg.sv | 51 +++++
 rtl/shift_op_decode.sv | 62 ++++++
 rtl/shift_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift sequencer.
// Contents: shift opcode encodings, shifter command encodings, the FSM state
// encoding, and a helper that picks the shift amount source.
// Optional feature macro: SHIFT_SEQ_ZERO_SKIP_EN (used in shift_sequencer.sv).
package shift_seq_pkg;

  // Shift opcodes presented on the op input.
  typedef enum logic [2:0] {
    OP_SLL     = 3'b000,
    OP_SRL     = 3'b001,
    OP_SRA     = 3'b010,
    OP_SLLV    = 3'b011,
    OP_SRLV    = 3'b100,
    OP_SRAV    = 3'b101,
    OP_SRA_A   = 3'b110,
    OP_ILLEGAL = 3'b111
  } shift_op_e;

  // Commands driven to the datapath shifter.
  typedef enum logic [2:0] {
    CTRL_NOP         = 3'b000,
    CTRL_LOAD        = 3'b001,
    CTRL_LEFT        = 3'b010,
    CTRL_RIGHT_LOG   = 3'b011,
    CTRL_RIGHT_ARITH = 3'b100
  } shift_ctrl_e;

  // Sequencer FSM states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_LOAD  = 3'b001,
    ST_SHIFT = 3'b010,
    ST_WRITE = 3'b011,
    ST_ERR   = 3'b100
  } seq_state_e;

  // Variable-amount ops take the count from the register file, others from
  // the instruction immediate.
  function automatic logic [4:0] select_amount(input logic use_reg,
                                               input logic [4:0] imm_amt,
                                               input logic [4:0] reg_amt);
    logic [4:0] amt;
    if (use_reg) begin
      amt = reg_amt;
    end else begin
      amt = imm_amt;
    end
    return amt;
  endfunction

endpackage

// File: rtl/shift_op_decode.sv
// Combinational opcode decoder for the shift sequencer.
// Ports:
//   op      in  [2:0] shift opcode
//   src_sel out       source select (1 = B_Out, 0 = A_Out)
//   amt_sel out       amount select (1 = reg_A_amt, 0 = shamt)
//   dir     out [2:0] shifter direction command used in the SHIFT cycle
//   illegal out       opcode has no defined operation
module shift_op_decode
  import shift_seq_pkg::*;
(
  input  logic [2:0] op,
  output logic       src_sel,
  output logic       amt_sel,
  output logic [2:0] dir,
  output logic       illegal
);

  // Map each opcode to its mux selects and shifter direction.
  always_comb begin
    src_sel = 1'b0;
    amt_sel = 1'b0;
    dir     = CTRL_NOP;
    illegal = 1'b0;
    case (op)
      OP_SLL: begin
        src_sel = 1'b1;
        dir     = CTRL_LEFT;
      end
      OP_SRL: begin
        src_sel = 1'b1;
        dir     = CTRL_RIGHT_LOG;
      end
      OP_SRA: begin
        src_sel = 1'b1;
        dir     = CTRL_RIGHT_ARITH;
      end
      OP_SLLV: begin
        src_sel = 1'b1;
        amt_sel = 1'b1;
        dir     = CTRL_LEFT;
      end
      OP_SRLV: begin
        src_sel = 1'b1;
        amt_sel = 1'b1;
        dir     = CTRL_RIGHT_LOG;
      end
      OP_SRAV: begin
        src_sel = 1'b1;
        amt_sel = 1'b1;
        dir     = CTRL_RIGHT_ARITH;
      end
      // SRA_A shifts the A operand, so the source mux stays on A_Out.
      OP_SRA_A: begin
        dir = CTRL_RIGHT_ARITH;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Shift sequencer: runs one shift operation per accepted start as
// LOAD -> SHIFT -> WRITE, or a one-cycle ERR for the illegal opcode.
// Ports:
//   clk            in        clock, rising edge
//   reset          in        asynchronous active-low reset
//   start          in        run request, sampled only while idle
//   op             in  [2:0] shift opcode
//   shamt          in  [4:0] immediate shift amount
//   reg_A_amt      in  [4:0] register-sourced shift amount
//   shift_src_sel  out       source mux select (1 = B_Out, 0 = A_Out)
//   shift_amt_sel  out       amount mux select (1 = reg_A_amt, 0 = shamt)
//   shift_ctrl     out [2:0] shifter command
//   shift_n        out [4:0] latched shift count
//   busy           out       high whenever not idle
//   done, reg_wr   out       one-cycle pulses in WRITE
//   error          out       one-cycle pulse in ERR
// Macro SHIFT_SEQ_ZERO_SKIP_EN: when defined, a zero shift count skips the
// SHIFT cycle (LOAD -> WRITE).
module shift_sequencer
  import shift_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [4:0] shamt,
  input  logic [4:0] reg_A_amt,
  output logic       shift_src_sel,
  output logic       shift_amt_sel,
  output logic [2:0] shift_ctrl,
  output logic [4:0] shift_n,
  output logic       busy,
  output logic       done,
  output logic       reg_wr,
  output logic       error
);

  seq_state_e state_r;
  logic [2:0] dir_r;
  logic       src_sel_s;
  logic       amt_sel_s;
  logic [2:0] dir_s;
  logic       illegal_s;

  // The decoder looks at the live opcode; its results are only captured
  // in IDLE, so later opcode changes cannot disturb a running operation.
  shift_op_decode u_decode (
    .op      (op),
    .src_sel (src_sel_s),
    .amt_sel (amt_sel_s),
    .dir     (dir_s),
    .illegal (illegal_s)
  );

  // Sequencer FSM; every output is registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      dir_r         <= CTRL_NOP;
      shift_src_sel <= 1'b0;
      shift_amt_sel <= 1'b0;
      shift_ctrl    <= CTRL_NOP;
      shift_n       <= 5'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      reg_wr        <= 1'b0;
      error         <= 1'b0;
    end else begin
      // Pulse outputs fall back to zero unless a state raises them.
      done   <= 1'b0;
      reg_wr <= 1'b0;
      error  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start && illegal_s) begin
            state_r       <= ST_ERR;
            busy          <= 1'b1;
            error         <= 1'b1;
            shift_src_sel <= 1'b0;
            shift_amt_sel <= 1'b0;
            shift_ctrl    <= CTRL_NOP;
          end else if (start) begin
            state_r       <= ST_LOAD;
            busy          <= 1'b1;
            dir_r         <= dir_s;
            shift_src_sel <= src_sel_s;
            shift_amt_sel <= amt_sel_s;
            shift_n       <= select_amount(amt_sel_s, shamt, reg_A_amt);
            shift_ctrl    <= CTRL_LOAD;
          end else begin
            busy       <= 1'b0;
            shift_ctrl <= CTRL_NOP;
          end
        end
        ST_LOAD: begin
`ifdef SHIFT_SEQ_ZERO_SKIP_EN
          // A zero count leaves the loaded value unchanged, so go straight
          // to the write-back.
          if (shift_n == 5'd0) begin
            state_r    <= ST_WRITE;
            shift_ctrl <= CTRL_NOP;
            done       <= 1'b1;
            reg_wr     <= 1'b1;
          end else begin
            state_r    <= ST_SHIFT;
            shift_ctrl <= dir_r;
          end
`else
          state_r    <= ST_SHIFT;
          shift_ctrl <= dir_r;
`endif
        end
        ST_SHIFT: begin
          state_r    <= ST_WRITE;
          shift_ctrl <= CTRL_NOP;
          done       <= 1'b1;
          reg_wr     <= 1'b1;
        end
        ST_WRITE: begin
          state_r       <= ST_IDLE;
          busy          <= 1'b0;
          shift_src_sel <= 1'b0;
          shift_amt_sel <= 1'b0;
          shift_ctrl    <= CTRL_NOP;
        end
        ST_ERR: begin
          state_r    <= ST_IDLE;
          busy       <= 1'b0;
          shift_ctrl <= CTRL_NOP;
        end
        default: begin
          state_r       <= ST_IDLE;
          busy          <= 1'b0;
          shift_src_sel <= 1'b0;
          shift_amt_sel <= 1'b0;
          shift_ctrl    <= CTRL_NOP;
        end
      endcase
    end
  end

endmodule
